// File: rtl/i2c_slave_regs_pkg.sv
// Shared definitions for the I2C register responder: FSM state encoding and
// the position of the R/W bit inside the address byte.
package i2c_slave_regs_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_MACK,
    S_IGNORE
  } state_t;

  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Parallel register port: the responder issues address/strobes, the register
// file returns read data.
interface i2c_slave_regs_if;

  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives edge and START/STOP
// pulses; independent of target/controller role.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus is high, so the chain resets to 1 to avoid a phantom START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target that converts bus transfers into single-cycle register read and
// write strobes with an auto-incrementing 8-bit pointer. SDA is open-drain.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  i2c_slave_regs_if.master regs,
  output logic             busy
);

  state_t     state, next_state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       sda_oe;
  logic       nack;
  logic       msb_go;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       re_q;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic       addr_match;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign sda            = sda_oe ? 1'b0 : 1'bz;
  assign regs.reg_addr  = addr_q;
  assign regs.reg_wdata = wdata_q;
  assign regs.reg_we    = we_q;
  assign regs.reg_re    = re_q;

  // General call (address 0) is never claimed, even if DEV_ADDR is 0.
  assign addr_match = (shreg[7:1] == DEV_ADDR) && (shreg[7:1] != 7'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state takes its default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    if (start_det) begin
      next_state = S_ADDR;
    end else if (stop_det) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_ADDR:      if (scl_fall && bit_cnt == 4'd8) next_state = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall) next_state = shreg[RW_BIT] ? S_READ : S_PTR;
        S_PTR:       if (scl_fall && bit_cnt == 4'd8) next_state = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall) next_state = S_WRITE;
        S_WRITE:     if (scl_fall && bit_cnt == 4'd8) next_state = S_WRITE_ACK;
        S_WRITE_ACK: if (scl_fall) next_state = S_WRITE;
        S_READ:      if (scl_fall && bit_cnt == 4'd7) next_state = S_MACK;
        S_MACK:      if (scl_fall) next_state = nack ? S_IGNORE : S_READ;
        default:     next_state = state;
      endcase
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      sda_oe  <= 1'b0;
      nack    <= 1'b0;
      msb_go  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      msb_go <= re_q;
      if (we_q || re_q) addr_q <= addr_q + 8'd1;
      if (re_q)         shreg  <= regs.reg_rdata;

      case (state)
        S_ADDR, S_PTR, S_WRITE:
          if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end
        S_READ:
          if (scl_fall) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        S_MACK:  if (scl_rise) nack <= sda_s;
        default: ;
      endcase

      // Any state change or START restarts the bit count; a partial byte is dropped.
      if (start_det || next_state != state) bit_cnt <= '0;

      if (state == S_PTR && next_state == S_PTR_ACK) addr_q <= shreg;
      if (state == S_WRITE && next_state == S_WRITE_ACK) begin
        wdata_q <= shreg;
        we_q    <= 1'b1;
      end
      if (next_state == S_READ && state != S_READ) re_q <= 1'b1;

      if (stop_det || (state == S_ADDR && next_state == S_IGNORE)) busy <= 1'b0;
      else if (state == S_ADDR && next_state == S_ADDR_ACK)       busy <= 1'b1;

      // Read data: MSB two clocks after the strobe, later bits on SCL falls.
      case (next_state)
        S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: sda_oe <= 1'b1;
        S_READ: begin
          if (state != S_READ) sda_oe <= 1'b0;
          else if (msb_go)     sda_oe <= ~shreg[7];
          else if (scl_fall)   sda_oe <= ~shreg[6];
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bus-level I2C controller model drives directed
// and random transfers; a scoreboard checks every register strobe.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam logic [6:0] DEV = 7'h50;
  localparam int         Q   = 200;  // quarter SCL period in ns (SCL = 40 clk)

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic scl       = 1'b1;
  logic m_sda_low = 1'b0;
  logic busy;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_regs_if rif ();
  assign rif.reg_rdata = rif.reg_addr ^ 8'h5A;

  i2c_slave_regs #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .regs  (rif),
    .busy  (busy)
  );

  always #10 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         dut_low_cnt = 0;
  exp_t       exp_q[$];
  logic [7:0] wbuf[$];
  logic [7:0] m_ptr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_strobe(input bit wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: pops one expectation per observed strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
    if (rif.reg_we || rif.reg_re) begin
      check("we_re_exclusive", 32'(rif.reg_we & rif.reg_re), 0);
      check("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_kind_we", 32'(rif.reg_we), 32'(e.wr));
        check("strobe_addr", 32'(rif.reg_addr), 32'(e.addr));
        if (e.wr) check("strobe_wdata", 32'(rif.reg_wdata), 32'(e.data));
      end
    end
  end

  task automatic bit_out(input logic b);
    m_sda_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda_low = 1'b0;
    #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    m_sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] b);
    b = '0;
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q scl = 1'b1;
      #Q b[i] = (sda !== 1'b0);
      #Q scl = 1'b0;
      #Q;
    end
    bit_out(~send_ack);
    m_sda_low = 1'b0;
  endtask

  // Write transfer: first byte in wbuf is the pointer, the rest are data.
  task automatic wr_txn(input logic [6:0] dev, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (dev == DEV) && (dev != 7'd0);
    i2c_start;
    write_byte({dev, 1'b0}, ack);
    check("addr_ack", 32'(ack), 32'(hit));
    check("busy_after_addr", 32'(busy), 32'(hit));
    for (int i = 0; i < wbuf.size(); i++) begin
      if (hit && i == 0) m_ptr = wbuf[0];
      else if (hit) begin
        expect_strobe(1'b1, m_ptr, wbuf[i]);
        m_ptr = m_ptr + 8'd1;
      end
      write_byte(wbuf[i], ack);
      check("data_ack", 32'(ack), 32'(hit));
    end
    wbuf.delete();
    if (do_stop) begin
      i2c_stop;
      check("busy_after_stop", 32'(busy), 0);
      check("reg_addr_after_wr", 32'(rif.reg_addr), 32'(m_ptr));
    end
  endtask

  // Read transfer after a repeated START; the last byte is NACKed.
  task automatic rd_txn(input int n);
    logic       ack;
    logic [7:0] b;
    logic [7:0] base;
    base = m_ptr;
    i2c_start;
    expect_strobe(1'b0, base, 8'h00);
    write_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 1);
    for (int k = 0; k < n; k++) begin
      if (k < n - 1) expect_strobe(1'b0, base + 8'(k + 1), 8'h00);
      read_byte(k < n - 1, b);
      check("rd_byte", 32'(b), 32'((base + 8'(k)) ^ 8'h5A));
    end
    m_ptr = base + 8'(n);
    check("sda_released_after_nack", 32'(sda === 1'b1), 1);
    i2c_stop;
    check("busy_after_rd", 32'(busy), 0);
    check("reg_addr_after_rd", 32'(rif.reg_addr), 32'(m_ptr));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [6:0] dev;
    int         nd;
    bit         do_rd;

    repeat (4) @(posedge clk);
    #1;
    check("rst_sda", 32'(sda === 1'b1), 1);
    check("rst_reg_addr", 32'(rif.reg_addr), 0);
    check("rst_reg_wdata", 32'(rif.reg_wdata), 0);
    check("rst_reg_we", 32'(rif.reg_we), 0);
    check("rst_reg_re", 32'(rif.reg_re), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    #(4*Q);

    // Write burst
    wbuf.push_back(8'h10); wbuf.push_back(8'hAA); wbuf.push_back(8'hBB);
    wr_txn(DEV, 1'b1);
    check("burst_final_addr", 32'(rif.reg_addr), 32'h12);

    // Random read via repeated START
    wbuf.push_back(8'h20);
    wr_txn(DEV, 1'b0);
    rd_txn(2);

    // Address mismatch and general call: SDA never pulled by the DUT
    dut_low_cnt = 0;
    wbuf.push_back(8'h55);
    wr_txn(7'h51, 1'b1);
    wbuf.push_back(8'h66);
    wr_txn(7'h00, 1'b1);
    check("mismatch_sda_untouched", 32'(dut_low_cnt), 0);

    // Pointer wrap
    wbuf.push_back(8'hFF); wbuf.push_back(8'h01); wbuf.push_back(8'h02);
    wr_txn(DEV, 1'b1);
    check("wrap_final_addr", 32'(rif.reg_addr), 32'h01);

    // Abort mid-byte: 4 data bits then STOP
    wbuf.push_back(8'h30);
    wr_txn(DEV, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(i[0]);
    i2c_stop;
    check("abort_busy", 32'(busy), 0);
    check("abort_reg_addr", 32'(rif.reg_addr), 32'(m_ptr));
    wr_txn(DEV, 1'b1);

    // Reset while the DUT drives a 0 data bit (0x20 ^ 0x5A = 0x7A, MSB 0)
    wbuf.push_back(8'h20);
    wr_txn(DEV, 1'b0);
    i2c_start;
    expect_strobe(1'b0, m_ptr, 8'h00);
    write_byte({DEV, 1'b1}, ack);
    check("rst_rd_addr_ack", 32'(ack), 1);
    check("rst_rd_dut_drives_0", 32'(sda === 1'b0), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sda", 32'(sda === 1'b1), 1);
    check("midrst_reg_addr", 32'(rif.reg_addr), 0);
    check("midrst_reg_wdata", 32'(rif.reg_wdata), 0);
    check("midrst_reg_we", 32'(rif.reg_we), 0);
    check("midrst_reg_re", 32'(rif.reg_re), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 8'h00;
    i2c_stop;

    // Random transfers against the model
    for (int t = 0; t < 10; t++) begin
      dev = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      nd  = $urandom_range(0, 3);
      wbuf.push_back(8'($urandom));
      for (int i = 0; i < nd; i++) wbuf.push_back(8'($urandom));
      do_rd = (dev == DEV) && ($urandom_range(0, 1) == 1);
      wr_txn(dev, !do_rd);
      if (do_rd) rd_txn($urandom_range(1, 3));
    end

    #(4*Q);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
